// File: rtl/nand3_stim_monitor.sv
// nand3_stim_monitor: drives IN1..3 of a 3-input NAND cell,
// checks QN after a settle time and counts QN toggles.
module nand3_stim_monitor #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rstb,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_nvec,
  input  logic             i_qn,
  output logic             o_in1,
  output logic             o_in2,
  output logic             o_in3,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_tog_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_fail
);

  // index must reach 8 in sweep mode even for tiny CNT_W
  localparam int unsigned IW = (CNT_W > 4) ? CNT_W : 4;
  localparam int unsigned WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_SWEEP = IW'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_FIN
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_nvec;
  logic [IW-1:0]    r_idx;
  logic [15:0]      r_lfsr;
  logic [2:0]       r_vec;
  logic [WW-1:0]    r_wcnt;
  logic             r_prev;
  logic             r_pvld;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_tog;
  logic [CNT_W-1:0] r_err;
  logic             r_fail;

  logic [15:0]   w_lfsr_nxt;
  logic          w_exp;
  logic [IW-1:0] w_idx_nxt;
  logic          w_last;

  assign w_lfsr_nxt = {r_lfsr[14:0],
                       r_lfsr[15] ^ r_lfsr[13] ^
                       r_lfsr[12] ^ r_lfsr[10]};
  assign w_exp      = ~&r_vec;
  assign w_idx_nxt  = r_idx + IW'(1);
  assign w_last     = r_mode ? (w_idx_nxt == IW'(r_nvec))
                             : (w_idx_nxt == IDX_SWEEP);

  assign o_in1     = r_vec[2];
  assign o_in2     = r_vec[1];
  assign o_in3     = r_vec[0];
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_tog_cnt = r_tog;
  assign o_err_cnt = r_err;
  assign o_fail    = r_fail;

  // run sequencer: vector drive, settle wait, sample and count
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_nvec  <= '0;
      r_idx   <= '0;
      r_lfsr  <= SEED;
      r_vec   <= 3'b000;
      r_wcnt  <= '0;
      r_prev  <= 1'b0;
      r_pvld  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tog   <= '0;
      r_err   <= '0;
      r_fail  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= |r_err;
      unique case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_vec  <= 3'b000;
          if (i_start) begin
            r_mode  <= i_mode;
            r_nvec  <= i_nvec;
            r_tog   <= '0;
            r_err   <= '0;
            r_fail  <= 1'b0;
            r_pvld  <= 1'b0;
            r_lfsr  <= SEED;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            if (i_mode && (i_nvec == '0))
              r_state <= S_FIN;
            else
              r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (r_mode) begin
            r_vec  <= r_lfsr[2:0];
            r_lfsr <= w_lfsr_nxt;
          end else begin
            r_vec  <= r_idx[2:0];
          end
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wcnt == W_LAST)
            r_state <= S_SAMPLE;
          else
            r_wcnt <= r_wcnt + WW'(1);
        end
        S_SAMPLE: begin
          // else-branch form so an X on QN counts as a mismatch
          if (i_qn == w_exp) begin
          end else if (~&r_err) begin
            r_err <= r_err + CNT_W'(1);
          end
          if (r_pvld && (i_qn != r_prev) && (~&r_tog))
            r_tog <= r_tog + CNT_W'(1);
          r_prev <= i_qn;
          r_pvld <= 1'b1;
          r_idx  <= w_idx_nxt;
          r_state <= w_last ? S_FIN : S_APPLY;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_vec   <= 3'b000;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
